// File: rtl/axi_soc_alu_slave.sv
// AXI-lite-style slave exposing operand/control/status registers and an iterative
// add/sub/mul/mac engine. Define AXI_SOC_ALU_IRQ_EN to add the level irq output.

module axi_soc_alu_slave #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   write_addr,
    input  logic                write_addr_valid,
    output logic                write_addr_ready,
    input  logic [DATA_W-1:0]   write_data,
    input  logic                write_data_valid,
    output logic                write_data_ready,
    output logic [1:0]          write_resp,
    output logic                write_resp_valid,
    input  logic                write_resp_ready,
    input  logic [ADDR_W-1:0]   read_addr,
    input  logic                read_addr_valid,
    output logic                read_addr_ready,
    output logic [DATA_W-1:0]   read_data,
    output logic [1:0]          read_resp,
    output logic                read_data_valid,
    input  logic                read_data_ready,
    output logic [2*DATA_W:0]   result
`ifdef AXI_SOC_ALU_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam int STRIDE  = DATA_W / 8;
    localparam int ALIGN_W = $clog2(STRIDE);
    localparam int RES_W   = 2 * DATA_W + 1;
    localparam int CNT_W   = $clog2(DATA_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {IDLE, CALC} state_e;

    typedef struct packed {
        logic       err;
        logic [2:0] idx;
    } dec_t;

    // Misaligned, below the base, or past RES_X all decode as an error.
    function automatic dec_t decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        dec_t              d;
        off   = addr - BASE_ADDR;
        d.err = (addr < BASE_ADDR) || ((off & ADDR_W'(STRIDE - 1)) != '0) ||
                ((off >> ALIGN_W) > ADDR_W'(6));
        d.idx = 3'(off >> ALIGN_W);
        return d;
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   aw_q;
    logic                aw_full_q;
    logic [DATA_W-1:0]   wd_q;
    logic                wd_full_q;
    logic                bvalid_q;
    logic [1:0]          bresp_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          rresp_q;
    logic [DATA_W-1:0]   op_a_q, op_b_q;
    logic [1:0]          opcode_q;
    logic [1:0]          calc_op_q, calc_op_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [RES_W-1:0]    prod_q, prod_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;

    logic                busy;
    logic                aw_hs, wd_hs, ar_hs;
    logic                wr_go, wr_err, wr_ok, start;
    dec_t                wdec, rdec;
    logic [DATA_W-1:0]   rd_val;
    logic                irq_en;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     hi_add;
    logic [RES_W-1:0]    prod_step;

    assign busy             = (state_q == CALC);
    // A pending response back-pressures both write channels.
    assign write_addr_ready = !rst && !aw_full_q && !bvalid_q;
    assign write_data_ready = !rst && !wd_full_q && !bvalid_q;
    assign read_addr_ready  = !rst && !rvalid_q;
    assign aw_hs            = write_addr_valid && write_addr_ready;
    assign wd_hs            = write_data_valid && write_data_ready;
    assign ar_hs            = read_addr_valid && read_addr_ready;

    assign wdec   = decode(aw_q);
    assign rdec   = decode(read_addr);
    assign wr_go  = aw_full_q && wd_full_q && !bvalid_q;
    assign wr_err = wdec.err || (wdec.idx > 3'd2) || busy;
    assign wr_ok  = wr_go && !wr_err;
    assign start  = wr_ok && (wdec.idx == 3'd2) && wd_q[2];

`ifdef AXI_SOC_ALU_IRQ_EN
    logic irq_en_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
        end else if (wr_ok && (wdec.idx == 3'd2)) begin
            irq_en_q <= wd_q[3];
        end
    end
    assign irq_en = irq_en_q;
    assign irq    = done_q & irq_en_q;
`else
    assign irq_en = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (rdec.idx)
            3'd0:    rd_val = op_a_q;
            3'd1:    rd_val = op_b_q;
            3'd2:    rd_val = DATA_W'({irq_en, 1'b0, opcode_q});
            3'd3:    rd_val = DATA_W'({done_q, busy});
            3'd4:    rd_val = result_q[DATA_W-1:0];
            3'd5:    rd_val = result_q[2*DATA_W-1:DATA_W];
            3'd6:    rd_val = DATA_W'(result_q[2*DATA_W]);
            default: rd_val = '0;
        endcase
        if (rdec.err) begin
            rd_val = '0;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        calc_op_d = calc_op_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        sum       = '0;
        hi_add    = '0;
        prod_step = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CALC;
                    calc_op_d = wd_q[1:0];
                    mcand_d   = op_a_q;
                    prod_d    = RES_W'(op_b_q);
                    cnt_d     = '0;
                    done_d    = 1'b0;
                end
            end
            CALC: begin
                if (!calc_op_q[1]) begin
                    if (calc_op_q[0]) begin
                        sum = {1'b0, mcand_q} - {1'b0, prod_q[DATA_W-1:0]};
                    end else begin
                        sum = {1'b0, mcand_q} + {1'b0, prod_q[DATA_W-1:0]};
                    end
                    result_d = RES_W'(sum);
                    state_d  = IDLE;
                    done_d   = 1'b1;
                end else begin
                    // Multiplier sits in the low half and shifts out as the product shifts in.
                    hi_add    = prod_q[RES_W-1:DATA_W] + (prod_q[0] ? {1'b0, mcand_q} : '0);
                    prod_step = {hi_add, prod_q[DATA_W-1:0]} >> 1;
                    prod_d    = prod_step;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        result_d = calc_op_q[0] ? (result_q + prod_step) : prod_step;
                        state_d  = IDLE;
                        done_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            aw_q      <= '0;
            aw_full_q <= 1'b0;
            wd_q      <= '0;
            wd_full_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            opcode_q  <= '0;
            calc_op_q <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            calc_op_q <= calc_op_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;

            if (aw_hs) begin
                aw_q      <= write_addr;
                aw_full_q <= 1'b1;
            end
            if (wd_hs) begin
                wd_q      <= write_data;
                wd_full_q <= 1'b1;
            end
            if (wr_go) begin
                aw_full_q <= 1'b0;
                wd_full_q <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && write_resp_ready) begin
                bvalid_q <= 1'b0;
            end

            if (wr_ok) begin
                case (wdec.idx)
                    3'd0:    op_a_q   <= wd_q;
                    3'd1:    op_b_q   <= wd_q;
                    3'd2:    opcode_q <= wd_q[1:0];
                    default: ;
                endcase
            end

            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
                rresp_q  <= rdec.err ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid_q && read_data_ready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign write_resp       = bresp_q;
    assign write_resp_valid = bvalid_q;
    assign read_data        = rdata_q;
    assign read_resp        = rresp_q;
    assign read_data_valid  = rvalid_q;
    assign result           = result_q;

endmodule

// File: tb/tb_axi_soc_alu_slave.sv
// Randomised scoreboard bench for axi_soc_alu_slave: a cycle-stamped behavioural model
// predicts every response; a monitor pops and compares whenever the DUT hands one over.

module tb_axi_soc_alu_slave;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int RES_W  = 2 * DATA_W + 1;
    localparam int STRIDE = DATA_W / 8;
    localparam logic [ADDR_W-1:0] BASE = 32'h4000_0100;

    logic                clk;
    logic                rst;
    logic [ADDR_W-1:0]   write_addr;
    logic                write_addr_valid;
    logic                write_addr_ready;
    logic [DATA_W-1:0]   write_data;
    logic                write_data_valid;
    logic                write_data_ready;
    logic [1:0]          write_resp;
    logic                write_resp_valid;
    logic                write_resp_ready;
    logic [ADDR_W-1:0]   read_addr;
    logic                read_addr_valid;
    logic                read_addr_ready;
    logic [DATA_W-1:0]   read_data;
    logic [1:0]          read_resp;
    logic                read_data_valid;
    logic                read_data_ready;
    logic [RES_W-1:0]    result;
`ifdef AXI_SOC_ALU_IRQ_EN
    logic                irq;
`endif

    axi_soc_alu_slave #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .write_addr      (write_addr),
        .write_addr_valid(write_addr_valid),
        .write_addr_ready(write_addr_ready),
        .write_data      (write_data),
        .write_data_valid(write_data_valid),
        .write_data_ready(write_data_ready),
        .write_resp      (write_resp),
        .write_resp_valid(write_resp_valid),
        .write_resp_ready(write_resp_ready),
        .read_addr       (read_addr),
        .read_addr_valid (read_addr_valid),
        .read_addr_ready (read_addr_ready),
        .read_data       (read_data),
        .read_resp       (read_resp),
        .read_data_valid (read_data_valid),
        .read_data_ready (read_data_ready),
        .result          (result)
`ifdef AXI_SOC_ALU_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    // Edge e sees the state left by edge e-1.
    logic [DATA_W-1:0] m_a, m_b;
    logic [1:0]        m_op;
    logic              m_irq_en;
    logic [RES_W-1:0]  m_res_old, m_res_new;
    longint            m_start, m_done_at;
    bit                m_started;

    function automatic bit m_busy(input longint e);
        return m_started && (e - 1 >= m_start) && (e - 1 < m_done_at);
    endfunction

    function automatic bit m_done(input longint e);
        return m_started && (e - 1 >= m_done_at);
    endfunction

    function automatic logic [RES_W-1:0] m_res(input longint e);
        return m_done(e) ? m_res_new : m_res_old;
    endfunction

    task automatic m_reset();
        m_a = '0; m_b = '0; m_op = '0; m_irq_en = 1'b0;
        m_res_old = '0; m_res_new = '0;
        m_start = 0; m_done_at = 0; m_started = 0;
    endtask

    function automatic bit m_decode(input logic [ADDR_W-1:0] addr, output int idx);
        longint off;
        idx = 0;
        if (addr < BASE) return 1'b1;
        off = longint'(addr) - longint'(BASE);
        idx = int'(off / STRIDE);
        return (off % STRIDE != 0) || (off / STRIDE > 6);
    endfunction

    task automatic m_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input longint p, output logic [1:0] resp);
        int               idx;
        bit               err;
        logic [RES_W-1:0] prev;
        logic [RES_W-1:0] nr;
        logic [DATA_W:0]  diff;
        err = m_decode(addr, idx);
        if (!err && (idx > 2 || m_busy(p))) err = 1'b1;
        resp = err ? 2'b10 : 2'b00;
        if (!err) begin
            case (idx)
                0: m_a = data;
                1: m_b = data;
                default: begin
                    m_op = data[1:0];
`ifdef AXI_SOC_ALU_IRQ_EN
                    m_irq_en = data[3];
`endif
                    if (data[2]) begin
                        prev = m_res(p);
                        diff = {1'b0, m_a} - {1'b0, m_b};
                        case (m_op)
                            2'd0:    nr = RES_W'(m_a) + RES_W'(m_b);
                            2'd1:    nr = RES_W'(diff);
                            2'd2:    nr = RES_W'(m_a) * RES_W'(m_b);
                            default: nr = prev + RES_W'(m_a) * RES_W'(m_b);
                        endcase
                        m_res_old = prev;
                        m_res_new = nr;
                        m_start   = p;
                        m_done_at = p + (m_op[1] ? DATA_W : 1);
                        m_started = 1;
                    end
                end
            endcase
        end
    endtask

    task automatic m_read(input logic [ADDR_W-1:0] addr, input longint r,
                          output logic [DATA_W-1:0] data, output logic [1:0] resp);
        int               idx;
        bit               err;
        logic [RES_W-1:0] res;
        err  = m_decode(addr, idx);
        res  = m_res(r);
        resp = err ? 2'b10 : 2'b00;
        data = '0;
        if (!err) begin
            case (idx)
                0: data = m_a;
                1: data = m_b;
                2: data = DATA_W'(m_op) | (m_irq_en ? DATA_W'(8) : '0);
                3: data = (m_done(r) ? DATA_W'(2) : '0) | (m_busy(r) ? DATA_W'(1) : '0);
                4: data = res[DATA_W-1:0];
                5: data = res[2*DATA_W-1:DATA_W];
                default: data = DATA_W'(res[2*DATA_W]);
            endcase
        end
    endtask

    // ---------------- scoreboard and monitor ----------------
    typedef struct {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
    } rexp_t;

    logic [1:0] wq[$];
    rexp_t      rq[$];
    logic [1:0] mon_w;
    rexp_t      mon_r;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && write_resp_valid && write_resp_ready) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected: got resp %0b, want none", write_resp);
                end else begin
                    mon_w = wq.pop_front();
                    check("write_resp", write_resp, mon_w);
                end
            end
            if (!rst && read_data_valid && read_data_ready) begin
                if (rq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected: got data %0h, want none", read_data);
                end else begin
                    mon_r = rq.pop_front();
                    check("read_data", read_data, mon_r.data);
                    check("read_resp", read_resp, mon_r.resp);
                end
            end
        end
    end

    // Response-side readies change just after the rising edge, stable at the monitor's sample point.
    bit hold_bready = 0;
    initial begin
        write_resp_ready = 1'b0;
        read_data_ready  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            write_resp_ready = hold_bready ? 1'b0 : ($urandom_range(0, 3) != 0);
            read_data_ready  = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- drivers ----------------
    function automatic logic [ADDR_W-1:0] reg_addr(input int idx);
        return BASE + ADDR_W'(idx * STRIDE);
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (wq.size() == 0 && rq.size() == 0) return;
            @(negedge clk);
        end
        timeout_fail("idle_wait");
        wq.delete();
        rq.delete();
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic [1:0] er;
        longint     acc;
        bit         ok;
        @(negedge clk);
        write_addr = a; write_data = d;
        write_addr_valid = 1'b1; write_data_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (write_addr_ready && write_data_ready) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            timeout_fail("wr_accept");
            write_addr_valid = 1'b0; write_data_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        write_addr_valid = 1'b0; write_data_valid = 1'b0;
        m_write(a, d, acc + 1, er);
        wq.push_back(er);
        @(negedge clk);
        check("wr_resp_early", write_resp_valid, 1'b0);
        @(negedge clk);
        check("wr_resp_valid", write_resp_valid, 1'b1);
        wait_idle();
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        rexp_t  e;
        longint acc;
        bit     ok;
        @(negedge clk);
        read_addr = a;
        read_addr_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (read_addr_ready) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            timeout_fail("rd_accept");
            read_addr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        read_addr_valid = 1'b0;
        m_read(a, acc, e.data, e.resp);
        rq.push_back(e);
        wait_idle();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_result", result, '0);
        check("rst_aw_ready", write_addr_ready, 1'b0);
        check("rst_w_ready", write_data_ready, 1'b0);
        check("rst_ar_ready", read_addr_ready, 1'b0);
        repeat (n) @(negedge clk);
        rst = 1'b0;
        m_reset();
        wq.delete();
        rq.delete();
        @(negedge clk);
        check("post_rst_aw_ready", write_addr_ready, 1'b1);
        check("post_rst_w_ready", write_data_ready, 1'b1);
        check("post_rst_ar_ready", read_addr_ready, 1'b1);
        check("post_rst_bvalid", write_resp_valid, 1'b0);
        check("post_rst_rvalid", read_data_valid, 1'b0);
        check("post_rst_result", result, '0);
    endtask

    task automatic check_result_port(input string name);
        @(negedge clk);
        check(name, result, m_res(cyc + 1));
`ifdef AXI_SOC_ALU_IRQ_EN
        check("irq", irq, m_done(cyc + 1) & m_irq_en);
`endif
    endtask

    // Data arrives three cycles ahead of its address; the response is held off for four cycles.
    task automatic bp_test(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic [1:0] er;
        longint     acc;
        bit         ok;
        hold_bready = 1;
        @(negedge clk);
        write_data = d;
        write_data_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (write_data_ready) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            timeout_fail("bp_data_accept");
            write_data_valid = 1'b0;
            hold_bready = 0;
            return;
        end
        @(posedge clk);
        #1;
        write_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_aw_ready_open", write_addr_ready, 1'b1);
        check("bp_w_ready_held", write_data_ready, 1'b0);
        write_addr = a;
        write_addr_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        write_addr_valid = 1'b0;
        m_write(a, d, acc + 1, er);
        wq.push_back(er);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_resp_valid", write_resp_valid, 1'b1);
            check("bp_aw_ready_low", write_addr_ready, 1'b0);
            check("bp_w_ready_low", write_data_ready, 1'b0);
        end
        hold_bready = 0;
        wait_idle();
        @(negedge clk);
        check("bp_aw_ready_back", write_addr_ready, 1'b1);
    endtask

    function automatic logic [DATA_W-1:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return DATA_W'($urandom);
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        write_addr = '0; write_addr_valid = 1'b0;
        write_data = '0; write_data_valid = 1'b0;
        read_addr  = '0; read_addr_valid  = 1'b0;
        m_reset();

        do_reset(2);
        do_read(reg_addr(3));

        // SUB 5 - 7
        do_write(reg_addr(0), 32'd5);
        do_write(reg_addr(1), 32'd7);
        do_write(reg_addr(2), 32'h5);
        do_read(reg_addr(3));
        do_read(reg_addr(4));
        do_read(reg_addr(5));
        do_read(reg_addr(6));
        check("sub_result", result, 65'h1_FFFF_FFFE);

        // MUL then MAC of all-ones operands, with STATUS polled while busy
        do_write(reg_addr(0), 32'hFFFF_FFFF);
        do_write(reg_addr(1), 32'hFFFF_FFFF);
        do_write(reg_addr(2), 32'h6);
        for (int i = 0; i < 10; i++) do_read(reg_addr(3));
        repeat (DATA_W + 4) @(negedge clk);
        check("mul_result", result, 65'h0_FFFF_FFFE_0000_0001);
        do_read(reg_addr(4));
        do_read(reg_addr(5));
        do_write(reg_addr(2), 32'h7);
        repeat (DATA_W + 4) @(negedge clk);
        check("mac_result", result, 65'h1_FFFF_FFFC_0000_0002);
        do_read(reg_addr(6));
        do_read(reg_addr(5));
        do_read(reg_addr(4));

        // Error responses, including operand write while busy
        do_write(reg_addr(2), 32'h6);
        do_write(reg_addr(0), 32'h1234);
        do_write(BASE + 32'h1C, 32'hDEAD);
        do_write(BASE + 32'h2, 32'hBEEF);
        do_write(BASE - 32'h4, 32'h1);
        do_write(reg_addr(3), 32'h3);
        do_read(BASE + 32'h1C);
        do_read(BASE + 32'h2);
        repeat (DATA_W + 4) @(negedge clk);
        do_read(reg_addr(0));
        check("op_a_kept", m_a, 32'hFFFF_FFFF);

        bp_test(reg_addr(1), 32'h0000_00A5);
        do_read(reg_addr(1));

        // Reset in the middle of a multiply
        do_write(reg_addr(2), 32'h6);
        while (cyc < m_start + 10) @(negedge clk);
        do_reset(1);
        do_read(reg_addr(3));
        do_write(reg_addr(0), 32'd1);
        do_write(reg_addr(1), 32'd2);
        do_write(reg_addr(2), 32'h4);
        do_read(reg_addr(4));
        check("add_after_rst", result, 65'd3);

        // Randomised traffic
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0, 1: do_write(reg_addr(0), rnd_val());
                2:    do_write(reg_addr(1), rnd_val());
                3, 4: do_write(reg_addr(2), DATA_W'($urandom_range(0, 15)));
                5, 6, 7: do_read(reg_addr($urandom_range(0, 7)));
                8:    do_read(BASE + ADDR_W'($urandom_range(0, 40)) - ADDR_W'(8));
                default: do_write(BASE + ADDR_W'($urandom_range(0, 40)) - ADDR_W'(8), rnd_val());
            endcase
            if ($urandom_range(0, 7) == 0) check_result_port("result_live");
        end
        repeat (DATA_W + 4) @(negedge clk);
        check_result_port("result_final");
        do_read(reg_addr(3));
        do_read(reg_addr(4));
        do_read(reg_addr(5));
        do_read(reg_addr(6));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "tb_axi_soc_alu_slave timeout");
    end

endmodule
